// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter/sequencer for the single-port word SDRAM model: port D (load/store) and port F (fetch).
// Optional grant/starvation statistics and memory-response checking are enabled with SDRAM_ARB_STATS_EN.
module sdram_port_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter logic [31:0] ADDR_LIMIT = 32'h0004_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wd,
  input  logic        d_we,
  input  logic [4:0]  d_rd,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic [4:0]  d_resp_rd,
  output logic        d_resp_we,
  output logic        d_resp_err,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [31:0] f_addr,
  output logic        f_resp_valid,
  output logic [31:0] f_resp_data,
  output logic        f_resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic [4:0]  mem_rd,
  output logic        mem_valid,
  input  logic [31:0] mem_loaded,
  input  logic        mem_valid_out,
  input  logic [4:0]  mem_rd_out,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_f_grants,
  output logic [31:0] stat_f_starve
);

  localparam int WW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic [WW-1:0] f_wait;
  logic          iss_f;
  logic          iss_we;
  logic          iss_err;
  logic [4:0]    iss_rd;

  logic          window;
  logic          f_prio;
  logic          d_acc;
  logic          f_acc;
  logic          d_oor;
  logic          f_oor;
  logic [31:0]   cap_data;

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign window   = (state != ISSUE) && !RST;
  assign f_prio   = (f_wait >= WW'(STARVE_MAX));
  assign d_ready  = window && d_valid && !(f_valid && f_prio);
  assign f_ready  = window && f_valid && (!d_valid || f_prio);
  assign d_acc    = d_valid && d_ready;
  assign f_acc    = f_valid && f_ready;
  assign d_oor    = (d_addr >= ADDR_LIMIT);
  assign f_oor    = (f_addr >= ADDR_LIMIT);
  assign cap_data = (iss_err || iss_we) ? 32'd0 : mem_loaded;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      f_wait       <= '0;
      iss_f        <= 1'b0;
      iss_we       <= 1'b0;
      iss_err      <= 1'b0;
      iss_rd       <= 5'd0;
      mem_addr     <= 32'd0;
      mem_wd       <= 32'd0;
      mem_we       <= 1'b0;
      mem_rd       <= 5'd0;
      mem_valid    <= 1'b0;
      d_resp_valid <= 1'b0;
      d_resp_data  <= 32'd0;
      d_resp_rd    <= 5'd0;
      d_resp_we    <= 1'b0;
      d_resp_err   <= 1'b0;
      f_resp_valid <= 1'b0;
      f_resp_data  <= 32'd0;
      f_resp_err   <= 1'b0;
    end else begin
      if (!f_valid || f_acc) begin
        f_wait <= '0;
      end else if (f_wait != WW'(STARVE_MAX)) begin
        f_wait <= f_wait + WW'(1);
      end

      case (state)
        IDLE, RESP: begin
          d_resp_valid <= 1'b0;
          f_resp_valid <= 1'b0;
          if (d_acc) begin
            state     <= ISSUE;
            iss_f     <= 1'b0;
            iss_we    <= d_we;
            iss_rd    <= d_rd;
            iss_err   <= d_oor;
            mem_addr  <= d_addr;
            mem_wd    <= d_wd;
            mem_we    <= d_we && !d_oor;
            mem_rd    <= d_rd;
            mem_valid <= !d_oor;
          end else if (f_acc) begin
            state     <= ISSUE;
            iss_f     <= 1'b1;
            iss_we    <= 1'b0;
            iss_rd    <= 5'd0;
            iss_err   <= f_oor;
            mem_addr  <= f_addr;
            mem_wd    <= 32'd0;
            mem_we    <= 1'b0;
            mem_rd    <= 5'd0;
            mem_valid <= !f_oor;
          end else begin
            state <= IDLE;
          end
        end

        ISSUE: begin
          state     <= RESP;
          mem_addr  <= 32'd0;
          mem_wd    <= 32'd0;
          mem_we    <= 1'b0;
          mem_rd    <= 5'd0;
          mem_valid <= 1'b0;
          if (iss_f) begin
            f_resp_valid <= 1'b1;
            f_resp_data  <= cap_data;
            f_resp_err   <= iss_err;
          end else begin
            d_resp_valid <= 1'b1;
            d_resp_data  <= cap_data;
            d_resp_rd    <= iss_rd;
            d_resp_we    <= iss_we;
            d_resp_err   <= iss_err;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic starve_win;

  // An override win is an F grant that only happened because F had waited too long.
  assign starve_win = f_acc && d_valid && f_prio;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_d_grants <= 32'd0;
      stat_f_grants <= 32'd0;
      stat_f_starve <= 32'd0;
    end else begin
      if (d_acc && stat_d_grants != 32'hFFFF_FFFF) stat_d_grants <= stat_d_grants + 32'd1;
      if (f_acc && stat_f_grants != 32'hFFFF_FFFF) stat_f_grants <= stat_f_grants + 32'd1;
      if (starve_win && stat_f_starve != 32'hFFFF_FFFF) stat_f_starve <= stat_f_starve + 32'd1;
    end
  end

  mem_resp_check: assert property (@(posedge CLK) disable iff (RST)
    (state == ISSUE && !iss_err) |-> (mem_valid_out && mem_rd_out == mem_rd));
`else
  logic unused_mem_resp;

  assign stat_d_grants   = 32'd0;
  assign stat_f_grants   = 32'd0;
  assign stat_f_starve   = 32'd0;
  assign unused_mem_resp = &{1'b0, mem_valid_out, mem_rd_out};
`endif

endmodule
